edge_detector_multi: RTL and testbench

//  Parametrised, multi-channel debounced edge detector for push-buttons and switch inputs.

---
 rtl/edge_detector_multi_if.sv | 33 +++
 rtl/edge_detector_multi.sv | 116 +++++++++++
 tb/tb_edge_detector_multi.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/edge_detector_multi_if.sv
// rtl/edge_detector_multi_if.sv - bus interface for edge_detector_multi
//
// Purpose: groups the raw inputs, mode select and detector outputs of
// edge_detector_multi into one bundle.
// Signals:
//   din       raw inputs, one bit per channel
//   mode      00 rising only, 01 falling only, 10 both, 11 pulses disabled
//   rising    one-cycle pulse per channel on accepted 0->1 edge
//   falling   one-cycle pulse per channel on accepted 1->0 edge
//   level     debounced level per channel
//   event_any OR of all rising and falling bits
// Modports: master drives din/mode, slave (the detector) drives the outputs.

interface edge_detector_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] din;
  logic [1:0]      mode;
  logic [N_CH-1:0] rising;
  logic [N_CH-1:0] falling;
  logic [N_CH-1:0] level;
  logic            event_any;

  modport master (
    output din, mode,
    input  rising, falling, level, event_any
  );

  modport slave (
    input  din, mode,
    output rising, falling, level, event_any
  );
endinterface

// File: rtl/edge_detector_multi.sv
// rtl/edge_detector_multi.sv - multi-channel debounced edge detector with lockout
//
// Purpose: each channel tracks a debounced level and emits a one-cycle pulse
// on accepted rising/falling edges; after every accepted edge the channel
// ignores its input for HOLD_CYCLES cycles.
// Ports:
//   clock  system clock, all logic on posedge
//   reset  synchronous, active-high reset
//   bus    edge_detector_multi_if.slave (din, mode in; rising, falling,
//          level, event_any out)
// Configuration macro: EDGE_DETECTOR_MULTI_SYNC_EN
//   defined   - each din bit passes a 2-flop synchroniser (latency 3 clocks)
//   undefined - din feeds the FSM directly (latency 1 clock)

module edge_detector_multi #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 130000
) (
  input  logic                  clock,
  input  logic                  reset,
  edge_detector_multi_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  logic [N_CH-1:0] din_s;
  logic [N_CH-1:0] rise_v;
  logic [N_CH-1:0] fall_v;
  logic [N_CH-1:0] level_v;
  logic            rise_en;
  logic            fall_en;

`ifdef EDGE_DETECTOR_MULTI_SYNC_EN
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.din;
      sync2_q <= sync1_q;
    end
  end

  assign din_s = sync2_q;
`else
  assign din_s = bus.din;
`endif

  // mode is consumed on the same edge an edge is accepted
  assign rise_en = (bus.mode == 2'b00) || (bus.mode == 2'b10);
  assign fall_en = (bus.mode == 2'b01) || (bus.mode == 2'b10);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        // pulses live for a single cycle; only the accepting IDLE branch re-raises them
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (din_s[i] != level_q) begin
              level_q <= din_s[i];
              cnt_q   <= '0;
              state_q <= LOCK;
              rise_q  <= din_s[i] & rise_en;
              fall_q  <= ~din_s[i] & fall_en;
            end
          end
          LOCK: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign rise_v[i]  = rise_q;
    assign fall_v[i]  = fall_q;
    assign level_v[i] = level_q;
  end

  assign bus.rising    = rise_v;
  assign bus.falling   = fall_v;
  assign bus.level     = level_v;
  assign bus.event_any = |{rise_v, fall_v};

endmodule

// File: tb/tb_edge_detector_multi.sv
// tb/tb_edge_detector_multi.sv - directed self-checking bench for edge_detector_multi

module tb_edge_detector_multi;

  localparam int N_CH = 4;
  localparam int HOLD = 8;
`ifdef EDGE_DETECTOR_MULTI_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  edge_detector_multi_if #(.N_CH(N_CH)) bus ();

  edge_detector_multi #(
    .N_CH        (N_CH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Ticks n times, counting pulses on channel ch and event_any, and noting
  // the cycle of the last pulse seen on each output.
  task automatic watch(input int n, input int ch,
                       output int nr, output int nf, output int ne,
                       output int last_r, output int last_f);
    nr = 0; nf = 0; ne = 0; last_r = -1; last_f = -1;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.rising[ch])  begin nr++; last_r = cyc; end
      if (bus.falling[ch]) begin nf++; last_f = cyc; end
      if (bus.event_any)   ne++;
    end
  endtask

  initial begin
    int nr, nf, ne, lr, lf;
    int tot_r, rise_cyc;

    reset    = 1'b1;
    bus.din  = '0;
    bus.mode = 2'b00;
    tick();
    tick();
    check("rst_rising",  bus.rising,    0);
    check("rst_falling", bus.falling,   0);
    check("rst_level",   bus.level,     0);
    check("rst_any",     bus.event_any, 0);
    reset = 1'b0;
    tick();
    check("post_rst_level", bus.level, 0);

    // 1: rising only, single edge on channel 0
    bus.mode = 2'b00;
    bus.din  = 4'b0001;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      check("s1_latency", bus.rising, (t == LAT) ? 4'b0001 : 4'b0000);
    end
    check("s1_level",   bus.level,     4'b0001);
    check("s1_falling", bus.falling,   4'b0000);
    check("s1_any",     bus.event_any, 1);
    tick();
    check("s1_width", bus.rising, 4'b0000);
    watch(12, 0, nr, nf, ne, lr, lf);
    check("s1_no_more", nr + nf, 0);

    // 2: both edges, bouncing channel 1 gives a single rising pulse
    bus.mode = 2'b10;
    tot_r    = 0;
    rise_cyc = -1;
    for (int b = 0; b < 5; b++) begin
      bus.din[1] = (b % 2 == 0);
      watch(1, 1, nr, nf, ne, lr, lf);
      tot_r += nr;
      if (nr != 0) rise_cyc = lr;
    end
    watch(15, 1, nr, nf, ne, lr, lf);
    tot_r += nr;
    if (nr != 0) rise_cyc = lr;
    check("s2_one_rise", tot_r, 1);
    check("s2_level",    bus.level, 4'b0011);
    bus.din[1] = 1'b0;
    watch(15, 1, nr, nf, ne, lr, lf);
    check("s2_one_fall", nf, 1);
    check("s2_gap",      (rise_cyc >= 0) && (lf - rise_cyc >= HOLD + 1), 1);

    // 3: falling only on channel 2
    bus.mode   = 2'b01;
    bus.din[2] = 1'b1;
    watch(20, 2, nr, nf, ne, lr, lf);
    check("s3_no_rise", nr, 0);
    check("s3_level",   bus.level, 4'b0101);
    bus.din[2] = 1'b0;
    for (int t = 1; t <= LAT + 1; t++) begin
      tick();
      check("s3_fall", bus.falling,   (t == LAT) ? 4'b0100 : 4'b0000);
      check("s3_any",  bus.event_any, (t == LAT));
    end
    watch(10, 2, nr, nf, ne, lr, lf);
    check("s3_no_more", nf, 0);

    // pulses disabled: level follows, no pulse
    bus.mode = 2'b11;
    bus.din  = 4'b0000;
    watch(12, 0, nr, nf, ne, lr, lf);
    check("m11_no_event", ne, 0);
    check("m11_level",    bus.level, 4'b0000);

    // 4: all channels together, falling held off by lockout
    bus.mode = 2'b10;
    bus.din  = 4'b1111;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      check("s4_rise", bus.rising, (t == LAT) ? 4'b1111 : 4'b0000);
    end
    check("s4_any", bus.event_any, 1);
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 3) bus.din = 4'b0000;
      check("s4_fall", bus.falling, (t == 9) ? 4'b1111 : 4'b0000);
      if (t == 8) check("s4_level_locked", bus.level, 4'b1111);
    end

    // 5: reset in the middle of a lockout
    watch(12, 3, nr, nf, ne, lr, lf);
    bus.din = 4'b1000;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      check("s5_rise", bus.rising, (t == LAT) ? 4'b1000 : 4'b0000);
    end
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("s5_rst_rising",  bus.rising,    0);
    check("s5_rst_falling", bus.falling,   0);
    check("s5_rst_level",   bus.level,     0);
    check("s5_rst_any",     bus.event_any, 0);
    tick();
    check("s5_rst_level2", bus.level, 0);
    reset = 1'b0;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      check("s5_fresh_rise", bus.rising, (t == LAT) ? 4'b1000 : 4'b0000);
    end
    check("s5_level", bus.level, 4'b1000);
    tick();
    check("s5_width", bus.rising, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
